// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - opcode classes, unit encoding and FSM states for the warp scheduler
package gpu_pkg;

  // Opcode class boundaries (6-bit opcode field)
  localparam int ALU_LO  = 0;
  localparam int ALU_HI  = 13;
  localparam int FPU_LO  = 14;
  localparam int FPU_HI  = 22;
  localparam int COND_LO = 23;
  localparam int COND_HI = 27;
  localparam int IO_LO   = 28;
  localparam int IO_HI   = 31;
  localparam int OP_STOP = 63;

  // One-hot unit select, bit order {io, condition, fpu, math}
  localparam logic [3:0] UNIT_NONE = 4'b0000;
  localparam logic [3:0] UNIT_MATH = 4'b0001;
  localparam logic [3:0] UNIT_FPU  = 4'b0010;
  localparam logic [3:0] UNIT_COND = 4'b0100;
  localparam logic [3:0] UNIT_IO   = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_NEXT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_FPU,
    CLS_COND,
    CLS_IO,
    CLS_STOP,
    CLS_ILL
  } cls_e;

  // Map a 6-bit opcode onto its execution class; anything unlisted is illegal
  function automatic cls_e classify(input logic [5:0] op);
    cls_e c;
    c = CLS_ILL;
    if (op <= 6'(ALU_HI) && 32'(op) >= 32'(ALU_LO))   c = CLS_ALU;
    else if (op >= 6'(FPU_LO) && op <= 6'(FPU_HI))    c = CLS_FPU;
    else if (op >= 6'(COND_LO) && op <= 6'(COND_HI))  c = CLS_COND;
    else if (op >= 6'(IO_LO) && op <= 6'(IO_HI))      c = CLS_IO;
    else if (op == 6'(OP_STOP))                       c = CLS_STOP;
    return c;
  endfunction

  function automatic logic [3:0] unit_of(input cls_e c);
    logic [3:0] u;
    case (c)
      CLS_ALU:  u = UNIT_MATH;
      CLS_FPU:  u = UNIT_FPU;
      CLS_COND: u = UNIT_COND;
      CLS_IO:   u = UNIT_IO;
      default:  u = UNIT_NONE;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/gpu_warp_scheduler_if.sv
// rtl/gpu_warp_scheduler_if.sv - issue bus between the scheduler and the execution units
interface gpu_warp_scheduler_if #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 72,
  parameter int TID_W   = 2
);
  logic [INSTR_W-1:0] issue_instr;
  logic [TID_W-1:0]   issue_tid;
  logic               issue_valid;
  logic [3:0]         issue_ready;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               math;
  logic               fpu;
  logic               condition;
  logic               io;

  modport master (
    output issue_instr, issue_tid, issue_valid, math, fpu, condition, io,
    input  issue_ready, br_taken, br_target
  );

  modport slave (
    input  issue_instr, issue_tid, issue_valid, math, fpu, condition, io,
    output issue_ready, br_taken, br_target
  );
endinterface

// File: rtl/gpu_rr_picker.sv
// rtl/gpu_rr_picker.sv - cyclic search for the next active thread after the current one
module gpu_rr_picker #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = 2
) (
  input  logic [NUM_THREADS-1:0] active_i,
  input  logic [TID_W-1:0]       rr_i,
  output logic [TID_W-1:0]       next_o
);

  int idx;

  // Walk offsets from far to near so the nearest active thread wins; offset
  // NUM_THREADS lands back on rr_i, covering the single-survivor case.
  always_comb begin
    next_o = rr_i;
    idx    = 0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      idx = (int'(rr_i) + i) % NUM_THREADS;
      if (active_i[idx]) next_o = TID_W'(idx);
    end
  end

endmodule

// File: rtl/gpu_warp_scheduler.sv
// rtl/gpu_warp_scheduler.sv - round-robin fetch/decode/issue scheduler for GPU threads
module gpu_warp_scheduler
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 4,
  parameter int INSTR_W     = 72
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_rdata,
  gpu_warp_scheduler_if.master iss,
  output logic                 stop,
  output logic                 illegal,
  output logic                 busy,
  output logic                 done
);

  localparam int TID_W = $clog2(NUM_THREADS);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q [NUM_THREADS];
  logic [PC_W-1:0]        pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q, active_d;
  logic [TID_W-1:0]       rr_q, rr_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  cls_e                   cls_q, cls_d;
  logic                   illegal_q, illegal_d;

  logic [TID_W-1:0]       rr_next;
  logic [NUM_THREADS-1:0] rr_bit;
  logic [3:0]             unit_sel;
  logic                   issue_valid;
  cls_e                   dec_cls;

  gpu_rr_picker #(
    .NUM_THREADS(NUM_THREADS),
    .TID_W      (TID_W)
  ) u_picker (
    .active_i(active_q),
    .rr_i    (rr_q),
    .next_o  (rr_next)
  );

  assign rr_bit  = NUM_THREADS'(1) << rr_q;
  assign dec_cls = classify(imem_rdata[INSTR_W-1 -: 6]);

  // Next-state, per-thread PC/mask updates and combinational outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    active_d    = active_q;
    rr_d        = rr_q;
    instr_d     = instr_q;
    cls_d       = cls_q;
    illegal_d   = illegal_q;
    imem_addr   = '0;
    stop        = 1'b0;
    done        = 1'b0;
    issue_valid = 1'b0;
    unit_sel    = UNIT_NONE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_THREADS; i++) pc_d[i] = start_pc;
          active_d  = '1;
          rr_d      = '0;
          illegal_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_addr = pc_q[rr_q];
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        instr_d = imem_rdata;
        cls_d   = dec_cls;
        if (dec_cls == CLS_STOP || dec_cls == CLS_ILL) begin
          active_d[rr_q] = 1'b0;
          stop           = 1'b1;
          if (dec_cls == CLS_ILL) illegal_d = 1'b1;
          if ((active_q & ~rr_bit) == '0) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_valid = 1'b1;
        unit_sel    = unit_of(cls_q);
        if ((iss.issue_ready & unit_sel) != 4'b0000) begin
          if (cls_q == CLS_COND && iss.br_taken) pc_d[rr_q] = iss.br_target;
          else                                   pc_d[rr_q] = pc_q[rr_q] + PC_W'(1);
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        rr_d    = rr_next;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and context registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= '0;
      active_q  <= '0;
      rr_q      <= '0;
      instr_q   <= '0;
      cls_q     <= CLS_ALU;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      active_q  <= active_d;
      rr_q      <= rr_d;
      instr_q   <= instr_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  assign iss.issue_valid = issue_valid;
  assign iss.issue_instr = issue_valid ? instr_q : '0;
  assign iss.issue_tid   = issue_valid ? rr_q : '0;
  assign iss.math        = unit_sel[0];
  assign iss.fpu         = unit_sel[1];
  assign iss.condition   = unit_sel[2];
  assign iss.io          = unit_sel[3];
  assign illegal         = illegal_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
